// File: rtl/bcd_stream_checker.sv
// Locks onto a 0..9 wrapping BCD digit stream, flags breaks and illegal codes,
// accumulates a tens digit from 9->0 wraps and drives a 2-digit multiplexed 7-segment display.
module bcd_stream_checker #(
    parameter int LOCK_CNT    = 3,
    parameter int REFRESH_DIV = 16,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             in_valid,
    output logic [3:0]       digit,
    output logic [3:0]       tens,
    output logic             locked,
    output logic             seq_err,
    output logic             bad_code,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       seg,
    output logic [1:0]       an
);
    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]     LOCK_RUN = 4'(LOCK_CNT);

    state_t           state_reg, state_next;
    logic [3:0]       digit_reg, digit_next;
    logic [3:0]       tens_reg, tens_next;
    logic [3:0]       expected_reg, expected_next;
    logic [3:0]       run_reg, run_next;
    logic             locked_reg, seq_err_reg, seq_err_next;
    logic             bad_code_reg, bad_code_next, wrap_reg, wrap_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic             err_inc;
    logic [CW-1:0]    refresh_reg;
    logic [6:0]       seg_reg;
    logic [1:0]       an_reg;
    logic [3:0]       s;

    assign s = {d, c, b, a};

    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    always_comb begin
        state_next    = state_reg;
        digit_next    = digit_reg;
        tens_next     = tens_reg;
        expected_next = expected_reg;
        run_next      = run_reg;
        seq_err_next  = 1'b0;
        bad_code_next = 1'b0;
        wrap_next     = 1'b0;
        err_inc       = 1'b0;
        if (in_valid) begin
            if (s > 4'd9) begin
                bad_code_next = 1'b1;
                err_inc       = 1'b1;
                state_next    = HUNT;
                run_next      = 4'd0;
            end else begin
                // every legal sample is accepted and reseeds the prediction
                digit_next    = s;
                expected_next = bcd_inc(s);
                case (state_reg)
                    HUNT: begin
                        run_next   = 4'd1;
                        state_next = CONFIRM;
                    end
                    CONFIRM: begin
                        if (s == expected_reg) begin
                            run_next = run_reg + 4'd1;
                            if (run_reg + 4'd1 >= LOCK_RUN)
                                state_next = LOCKED;
                        end else begin
                            run_next = 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (s == expected_reg) begin
                            if (s == 4'd0) begin
                                tens_next = bcd_inc(tens_reg);
                                wrap_next = 1'b1;
                            end
                        end else begin
                            seq_err_next = 1'b1;
                            err_inc      = 1'b1;
                            run_next     = 4'd1;
                            state_next   = CONFIRM;
                        end
                    end
                    default: state_next = HUNT;
                endcase
            end
        end
        err_next = (err_inc && err_reg != '1) ? err_reg + 1'b1 : err_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= HUNT;
            digit_reg    <= 4'd0;
            tens_reg     <= 4'd0;
            expected_reg <= 4'd0;
            run_reg      <= 4'd0;
            locked_reg   <= 1'b0;
            seq_err_reg  <= 1'b0;
            bad_code_reg <= 1'b0;
            wrap_reg     <= 1'b0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            digit_reg    <= digit_next;
            tens_reg     <= tens_next;
            expected_reg <= expected_next;
            run_reg      <= run_next;
            locked_reg   <= (state_next == LOCKED);
            seq_err_reg  <= seq_err_next;
            bad_code_reg <= bad_code_next;
            wrap_reg     <= wrap_next;
            err_reg      <= err_next;
        end
    end

    // an=10 means units is showing; the toggle loads the pattern of the other digit
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_reg <= '0;
            an_reg      <= 2'b10;
            seg_reg     <= 7'b1000000;
        end else if (refresh_reg == REF_LAST) begin
            refresh_reg <= '0;
            an_reg      <= ~an_reg;
            seg_reg     <= (an_reg == 2'b10) ? seg7(tens_reg) : seg7(digit_reg);
        end else begin
            refresh_reg <= refresh_reg + 1'b1;
        end
    end

    assign digit     = digit_reg;
    assign tens      = tens_reg;
    assign locked    = locked_reg;
    assign seq_err   = seq_err_reg;
    assign bad_code  = bad_code_reg;
    assign wrap      = wrap_reg;
    assign err_count = err_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;
endmodule

// File: tb/tb_bcd_stream_checker.sv
// Directed bench for bcd_stream_checker: locking, wraps, errors, saturation, display and reset.
module tb_bcd_stream_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, in_valid = 1'b0;
    logic [3:0] digit, tens;
    logic       locked, seq_err, bad_code, wrap;
    logic [7:0] err_count;
    logic [6:0] seg;
    logic [1:0] an;

    int tests = 0;
    int fails = 0;

    bcd_stream_checker #(.LOCK_CNT(3), .REFRESH_DIV(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .digit(digit), .tens(tens), .locked(locked), .seq_err(seq_err),
        .bad_code(bad_code), .wrap(wrap), .err_count(err_count), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] s, input logic v);
        @(negedge clk);
        {d, c, b, a} = s;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_digit"}, 32'(digit), 0);
        chk({tag, "_tens"}, 32'(tens), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_pulses"}, 32'({seq_err, bad_code, wrap}), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_an"}, 32'(an), 32'b10);
        chk({tag, "_seg"}, 32'(seg), 32'b1000000);
    endtask

    initial begin
        logic [1:0] an_prev;
        int         n;
        logic [3:0] tens_m;
        logic [3:0] sv;

        // reset
        rst = 1'b0;
        send(4'd5, 1'b1);
        send(4'd5, 1'b1);
        chk_reset_values("reset");
        rst = 1'b1;

        // lock on 0,1,2 then 3
        send(4'd0, 1'b1); chk("lock_s0_locked", 32'(locked), 0); chk("lock_s0_digit", 32'(digit), 0);
        send(4'd1, 1'b1); chk("lock_s1_locked", 32'(locked), 0);
        send(4'd2, 1'b1); chk("lock_s2_locked", 32'(locked), 1); chk("lock_s2_digit", 32'(digit), 2);
        send(4'd3, 1'b1); chk("lock_s3_digit", 32'(digit), 3); chk("lock_s3_locked", 32'(locked), 1);
        chk("lock_s3_seq_err", 32'(seq_err), 0); chk("lock_s3_err", 32'(err_count), 0);

        // locked stream up to wrap
        for (int k = 4; k <= 9; k++) begin
            send(4'(k), 1'b1);
            chk("run_wrap0", 32'(wrap), 0);
        end
        send(4'd0, 1'b1); chk("wrap_pulse", 32'(wrap), 1); chk("wrap_tens", 32'(tens), 1);
        chk("wrap_seq_err", 32'(seq_err), 0);
        send(4'd1, 1'b1); chk("wrap_clear", 32'(wrap), 0); chk("wrap_tens_hold", 32'(tens), 1);

        // sequence break at 4 -> 6
        send(4'd2, 1'b1); send(4'd3, 1'b1); send(4'd4, 1'b1);
        chk("pre_break_locked", 32'(locked), 1);
        send(4'd6, 1'b1);
        chk("break_seq_err", 32'(seq_err), 1); chk("break_err", 32'(err_count), 1);
        chk("break_locked", 32'(locked), 0); chk("break_digit", 32'(digit), 6);
        send(4'd7, 1'b1); chk("break_pulse_end", 32'(seq_err), 0); chk("break_s7_locked", 32'(locked), 0);
        send(4'd8, 1'b1); chk("relock_s8", 32'(locked), 1);

        // illegal code while locked
        send(4'd12, 1'b1);
        chk("bad_pulse", 32'(bad_code), 1); chk("bad_err", 32'(err_count), 2);
        chk("bad_locked", 32'(locked), 0); chk("bad_digit", 32'(digit), 8);
        send(4'd5, 1'b1); chk("bad_pulse_end", 32'(bad_code), 0); chk("bad_s5_locked", 32'(locked), 0);
        send(4'd6, 1'b1); chk("bad_s6_locked", 32'(locked), 0);
        send(4'd7, 1'b1); chk("bad_relock", 32'(locked), 1); chk("bad_relock_digit", 32'(digit), 7);

        // in_valid gaps hold state, including with illegal data on the lines
        for (int k = 0; k < 3; k++) begin
            send(4'd12, 1'b0);
            chk("gap_digit", 32'(digit), 7); chk("gap_locked", 32'(locked), 1);
            chk("gap_err", 32'(err_count), 2); chk("gap_pulses", 32'({seq_err, bad_code, wrap}), 0);
        end
        send(4'd8, 1'b1); chk("gap_resume_digit", 32'(digit), 8); chk("gap_resume_seq", 32'(seq_err), 0);

        // break to 3: tens survives loss of lock
        send(4'd3, 1'b1);
        chk("brk3_seq_err", 32'(seq_err), 1); chk("brk3_err", 32'(err_count), 3);
        chk("brk3_tens", 32'(tens), 1); chk("brk3_digit", 32'(digit), 3);

        // display: digit=3 (0110000 on an=10), tens=1 (1111001 on an=01), period 16
        send(4'd0, 1'b0);
        an_prev = an; n = 0;
        while (an === an_prev && n < 40) begin @(posedge clk); #1; n++; end
        chk("disp_first_toggle_seen", 32'(n < 40), 1);
        for (int t = 0; t < 4; t++) begin
            chk("disp_an_legal", 32'(an == 2'b10 || an == 2'b01), 1);
            chk("disp_seg", 32'(seg), (an == 2'b10) ? 32'b0110000 : 32'b1111001);
            an_prev = an; n = 0;
            while (an === an_prev && n < 40) begin @(posedge clk); #1; n++; end
            chk("disp_period", 32'(n), 16);
        end

        // error counter saturation: 3 + 252 = 255, then stays
        for (int k = 0; k < 252; k++) send(4'd10 + 4'(k % 6), 1'b1);
        chk("sat_reach", 32'(err_count), 255); chk("sat_bad", 32'(bad_code), 1);
        for (int k = 0; k < 48; k++) send(4'd15, 1'b1);
        chk("sat_hold", 32'(err_count), 255); chk("sat_locked", 32'(locked), 0);

        // relock, then nine wraps take tens 1 -> 0
        send(4'd0, 1'b1); send(4'd1, 1'b1); send(4'd2, 1'b1);
        chk("wrapseq_locked", 32'(locked), 1);
        tens_m = 4'd1;
        for (int k = 3; k <= 92; k++) begin
            sv = 4'(k % 10);
            send(sv, 1'b1);
            if (sv == 4'd0) tens_m = (tens_m == 4'd9) ? 4'd0 : tens_m + 4'd1;
            chk("wrapseq_wrap", 32'(wrap), 32'(sv == 4'd0));
            chk("wrapseq_tens", 32'(tens), 32'(tens_m));
        end
        chk("wrapseq_tens_final", 32'(tens), 0);
        chk("wrapseq_err_hold", 32'(err_count), 255);

        // reset mid-lock
        rst = 1'b0;
        send(4'd3, 1'b1);
        chk_reset_values("midreset");
        rst = 1'b1;
        send(4'd4, 1'b1);
        chk("post_reset_hunt_locked", 32'(locked), 0); chk("post_reset_digit", 32'(digit), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_stream_checker.md
Name: bcd_stream_checker

Overview:
- Receiver and checker for the 4-bit BCD digit stream produced by the team's mod-10 counter, presented as single-bit lines a (LSB), b, c, d (MSB).
- Locks onto the 0..9 increment-and-wrap sequence, flags sequence breaks and illegal codes, and builds a tens digit from 9->0 wraps.
- Drives a 2-digit multiplexed 7-segment display showing tens and units.
- Sits between the counter and the board display pins.

Parameters:
- LOCK_CNT, 3: consecutive in-sequence samples needed to enter LOCKED (range 2..15).
- REFRESH_DIV, 16: clock cycles each display digit stays selected (>=2).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- a  in  1  digit bit 0.
- b  in  1  digit bit 1.
- c  in  1  digit bit 2.
- d  in  1  digit bit 3.
- in_valid  in  1  sample {d,c,b,a} on this edge.
- digit  out  4  last accepted legal sample.
- tens  out  4  tens digit, 0..9.
- locked  out  1  checker in LOCKED state.
- seq_err  out  1  one-cycle pulse on a sequence break while LOCKED.
- bad_code  out  1  one-cycle pulse when a valid sample is >9.
- wrap  out  1  one-cycle pulse when tens increments.
- err_count  out  ERR_W  saturating count of seq_err plus bad_code events.
- seg  out  7  active-low segments, seg[0]=a ... seg[6]=g.
- an  out  2  active-low digit select; an[0]=units, an[1]=tens.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low: rst=0 sampled on a rising clk edge resets the block. Reset dominates all other inputs.
- Reset values:
  - state=HUNT, digit=0, tens=0, locked=0, seq_err=0, bad_code=0, wrap=0, err_count=0.
  - expected=0, run=0, refresh counter=0, an=2'b10, seg=7'b1000000.
- Sampling: the input word is s={d,c,b,a}. Inputs are ignored when in_valid=0; state and counters hold, and all pulses are 0. All outputs are registered, so the response to a sample appears after the sampling edge (1-cycle latency).
- Illegal code (s>9, any state):
  - bad_code=1 for one cycle.
  - err_count increments, saturating at all-ones.
  - state goes to HUNT with run=0; digit is not updated.
- HUNT: on a legal s, set digit=s, expected=(s+1) mod 10, run=1, and go to CONFIRM.
- CONFIRM:
  - s==expected: digit=s, expected advances mod 10, run++. If run reaches LOCK_CNT, go to LOCKED and set locked=1.
  - s!=expected (legal): reseed with run=1 and expected=(s+1) mod 10. Stay in CONFIRM. No error is raised.
- LOCKED:
  - s==expected: digit=s and expected advances. If s==0, tens=(tens+1) mod 10 and wrap=1 for one cycle.
  - s!=expected (legal): seq_err=1 for one cycle, err_count increments (saturating), locked=0, then reseed exactly as in CONFIRM and go to CONFIRM.
- tens changes only on a LOCKED wrap or on reset. tens is not cleared on loss of lock.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of in_valid.
  - On terminal count, an toggles between 2'b10 and 2'b01. seg is loaded in the same edge with the pattern of the newly selected digit (units=digit, tens=tens).
  - Between toggles, seg and an hold, even if digit or tens change.
- Segment patterns (seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Wrap boundaries: expected after 9 is 0. tens after 9 is 0; wrap still pulses.
- Reset mid-lock: returns to HUNT; tens and err_count are cleared.

Test Plan:
- Reset, then in_valid every cycle with s=0,1,2,3 -> locked=1 on the edge that samples 2 (LOCK_CNT=3); digit=3; seq_err and err_count stay 0.
- Locked stream 7,8,9,0,1 -> wrap pulses once on the edge sampling 0; tens goes 0->1; no seq_err.
- Locked at 4, then inject 6 -> seq_err=1 for one cycle, err_count=1, locked=0, state CONFIRM. Continue 7,8 -> locked=1 again after sampling 8.
- Inject s=12 while locked -> bad_code=1, err_count increments, locked=0, digit unchanged. Then 5,6,7 -> relock.
- 300 illegal samples with ERR_W=8 -> err_count saturates at 255 and does not wrap.
- in_valid=0 gaps inside a locked sequence -> no state change. Display with tens=1, digit=3, REFRESH_DIV=16 -> an toggles every 16 cycles; seg alternates 0110000 (an=10) and 1111001 (an=01). rst=0 for one edge -> all reset values.
